// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the one-hot scan decoder.
// Mode encodings plus a width-agnostic one-hot builder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_CH = 256;

  // Callers size-cast the result down to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx < n) ? (MAX_CH'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Scan-step prescaler: pulses tick once every DIV enabled cycles.
// Ports: clk, rst (sync, high), en (count/hold), clr (force 0), tick.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == TOP);
  assign tick = en & last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with prescaled scan mode.
// Ports: clk, rst (sync, high), mode, en, code_in -> data_out, index_out, wrap.
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned TICK_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              en,
  input  logic [CODE_W-1:0] code_in,
  output logic [NUM_CH-1:0] data_out,
  output logic [CODE_W-1:0] index_out,
  output logic              wrap
);

  localparam logic [CODE_W-1:0] LAST = CODE_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] SEL0 = NUM_CH'(1);

  logic              scan;
  logic              tick;
  logic [CODE_W-1:0] idx_d;
  logic              wrap_d;
  logic [NUM_CH-1:0] sel;

  assign scan = (mode == MODE_SCAN);

  // Direct mode pins the prescaler at 0 so a later
  // switch to scan always starts a full step.
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en & scan),
    .clr  (en & ~scan),
    .tick (tick)
  );

  always_comb begin
    idx_d  = index_out;
    wrap_d = 1'b0;
    if (en) begin
      if (!scan) begin
        idx_d = (32'(code_in) < NUM_CH) ? code_in : '0;
      end else if (tick) begin
        if (index_out == LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = index_out + 1'b1;
        end
      end
    end
    // Decode the next index so data_out never lags index_out.
    sel = en ? NUM_CH'(onehot(32'(idx_d), NUM_CH)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_out <= '0;
      data_out  <= ACTIVE_LOW ? ~SEL0 : SEL0;
      wrap      <= 1'b0;
    end else begin
      index_out <= idx_d;
      data_out  <= ACTIVE_LOW ? ~sel : sel;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed testbench for onehot_scan_decoder.
// Three instances cover 8ch/div4, 6ch direct clamp, 4ch active-low div1.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, mode, en;
  logic [2:0] code;
  logic       rst_c, mode_c, en_c;
  logic [2:0] code_c;

  logic [7:0] da;
  logic [2:0] ia;
  logic       wa;
  logic [5:0] db;
  logic [2:0] ib;
  logic       wb;
  logic [3:0] dc;
  logic [2:0] ic;
  logic       wc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(
    .CODE_W(3), .NUM_CH(8), .TICK_DIV(4), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .code_in(code),
    .data_out(da), .index_out(ia), .wrap(wa)
  );

  onehot_scan_decoder #(
    .CODE_W(3), .NUM_CH(6), .TICK_DIV(4), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .code_in(code),
    .data_out(db), .index_out(ib), .wrap(wb)
  );

  onehot_scan_decoder #(
    .CODE_W(3), .NUM_CH(4), .TICK_DIV(1), .ACTIVE_LOW(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst_c), .mode(mode_c), .en(en_c), .code_in(code_c),
    .data_out(dc), .index_out(ic), .wrap(wc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; en = 1'b1; code = 3'd0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (da !== 8'h01 || ia !== 3'd0 || wa !== 1'b0) begin
        bad++;
        $display("FAIL reset%0d: got d=%h i=%0d w=%b want 01/0/0",
                 k, da, ia, wa);
      end
    end
  endtask

  task automatic test_scan();
    logic [2:0] ei;
    logic [7:0] ed;
    rst = 1'b0; mode = 1'b1; en = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      ei = 3'((k / 4) % 8);
      ed = 8'h01 << ei;
      total++;
      if (da !== ed || ia !== ei || wa !== (k == 32)) begin
        bad++;
        $display("FAIL scan k=%0d: got d=%h i=%0d w=%b want %h/%0d/%b",
                 k, da, ia, wa, ed, ei, (k == 32));
      end
    end
  endtask

  task automatic test_enable();
    mode = 1'b1; en = 1'b1;
    do_reset();
    for (int i = 0; i < 14; i++) step();
    total++;
    if (ia !== 3'd3 || da !== 8'h08) begin
      bad++;
      $display("FAIL en_pre: got d=%h i=%0d want 08/3", da, ia);
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (da !== 8'h00 || ia !== 3'd3 || wa !== 1'b0) begin
        bad++;
        $display("FAIL en_off%0d: got d=%h i=%0d w=%b want 00/3/0",
                 k, da, ia, wa);
      end
    end
    en = 1'b1;
    step();
    total++;
    if (da !== 8'h08 || ia !== 3'd3) begin
      bad++;
      $display("FAIL en_on1: got d=%h i=%0d want 08/3", da, ia);
    end
    step();
    total++;
    if (da !== 8'h10 || ia !== 3'd4) begin
      bad++;
      $display("FAIL en_on2: got d=%h i=%0d want 10/4", da, ia);
    end
  endtask

  task automatic test_mode_switch();
    logic [2:0] ei;
    mode = 1'b1; en = 1'b1; code = 3'd0;
    do_reset();
    for (int i = 0; i < 31; i++) step();
    total++;
    if (ia !== 3'd7) begin
      bad++;
      $display("FAIL sw_pre: got i=%0d want 7", ia);
    end
    mode = 1'b0; code = 3'd1;
    step();
    total++;
    if (ia !== 3'd1 || da !== 8'h02 || wa !== 1'b0) begin
      bad++;
      $display("FAIL sw_direct: got d=%h i=%0d w=%b want 02/1/0",
               da, ia, wa);
    end
    mode = 1'b1; code = 3'd6;
    for (int k = 1; k <= 4; k++) begin
      step();
      ei = (k < 4) ? 3'd1 : 3'd2;
      total++;
      if (ia !== ei || wa !== 1'b0) begin
        bad++;
        $display("FAIL sw_scan k=%0d: got i=%0d w=%b want %0d/0",
                 k, ia, wa, ei);
      end
    end
  endtask

  task automatic test_direct();
    mode = 1'b0; en = 1'b1;
    code = 3'd5;
    step();
    total++;
    if (da !== 8'h20 || ia !== 3'd5 || db !== 6'h20) begin
      bad++;
      $display("FAIL dir5: got a=%h i=%0d b=%h want 20/5/20", da, ia, db);
    end
    code = 3'd7;
    step();
    total++;
    if (da !== 8'h80 || ia !== 3'd7 || db !== 6'h01 || ib !== 3'd0) begin
      bad++;
      $display("FAIL dir7: got a=%h i=%0d b=%h ib=%0d want 80/7/01/0",
               da, ia, db, ib);
    end
    code = 3'd6;
    step();
    total++;
    if (db !== 6'h01 || ib !== 3'd0 || da !== 8'h40) begin
      bad++;
      $display("FAIL dir6: got b=%h ib=%0d a=%h want 01/0/40", db, ib, da);
    end
    code = 3'd0;
    step();
    total++;
    if (da !== 8'h01 || wa !== 1'b0) begin
      bad++;
      $display("FAIL dir0: got d=%h w=%b want 01/0", da, wa);
    end
    en = 1'b0; code = 3'd3;
    step();
    total++;
    if (da !== 8'h00 || ia !== 3'd0 || db !== 6'h00) begin
      bad++;
      $display("FAIL dir_off: got a=%h i=%0d b=%h want 00/0/00",
               da, ia, db);
    end
  endtask

  task automatic test_active_low();
    logic [3:0] seq [4];
    seq[0] = 4'hD; seq[1] = 4'hB; seq[2] = 4'h7; seq[3] = 4'hE;
    rst_c = 1'b1; mode_c = 1'b1; en_c = 1'b1; code_c = 3'd0;
    step();
    total++;
    if (dc !== 4'hE || ic !== 3'd0 || wc !== 1'b0) begin
      bad++;
      $display("FAIL al_reset: got d=%h i=%0d w=%b want E/0/0",
               dc, ic, wc);
    end
    rst_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (dc !== seq[k] || wc !== (k == 3)) begin
        bad++;
        $display("FAIL al_scan k=%0d: got d=%h w=%b want %h/%b",
                 k, dc, wc, seq[k], (k == 3));
      end
    end
    en_c = 1'b0;
    step();
    total++;
    if (dc !== 4'hF || ic !== 3'd0 || wc !== 1'b0) begin
      bad++;
      $display("FAIL al_off: got d=%h i=%0d w=%b want F/0/0", dc, ic, wc);
    end
    en_c = 1'b1; mode_c = 1'b0; code_c = 3'd5;
    step();
    total++;
    if (dc !== 4'hE || ic !== 3'd0) begin
      bad++;
      $display("FAIL al_clamp: got d=%h i=%0d want E/0", dc, ic);
    end
    code_c = 3'd2;
    step();
    total++;
    if (dc !== 4'hB || ic !== 3'd2) begin
      bad++;
      $display("FAIL al_dir2: got d=%h i=%0d want B/2", dc, ic);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; en = 1'b0; code = 3'd0;
    rst_c = 1'b1; mode_c = 1'b0; en_c = 1'b0; code_c = 3'd0;
    step();
    test_reset();
    test_scan();
    test_enable();
    test_mode_switch();
    test_direct();
    test_active_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
